// File: rtl/dct8_transpose_buf_if.sv
// -----------------------------------------------------------------------------
// dct8_transpose_buf_if
//   Row/column stream bundle for the 8x8 DCT transpose buffer.
//   Row side   : in_valid, in_ready, in0..in7 (inK = column K of the row).
//   Column side: out_valid, out_ready, out0..out7 (outK = row K of the column),
//                out_col (column index 0..7), out_last (column 7 of a block).
//   Modports:
//     master - the environment: drives rows and out_ready, observes columns.
//     slave  - the buffer: accepts rows, presents columns.
// -----------------------------------------------------------------------------
interface dct8_transpose_buf_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in0, in1, in2, in3, in4, in5, in6, in7;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
   logic [2:0]        out_col;
   logic              out_last;

   modport master (
      output in_valid, in0, in1, in2, in3, in4, in5, in6, in7,
      input  in_ready,
      input  out_valid, out0, out1, out2, out3, out4, out5, out6, out7,
      input  out_col, out_last,
      output out_ready
   );

   modport slave (
      input  in_valid, in0, in1, in2, in3, in4, in5, in6, in7,
      output in_ready,
      output out_valid, out0, out1, out2, out3, out4, out5, out6, out7,
      output out_col, out_last,
      input  out_ready
   );
endinterface

// File: rtl/dct8_transpose_buf.sv
// -----------------------------------------------------------------------------
// dct8_transpose_buf
//   Ping-pong transpose buffer between the row and column 8-point DCT passes.
//   Rows of an 8x8 block are written one per beat into one bank while the
//   other bank is read out one column per beat. A per-bank full flag decides
//   ownership: a bank is writable while empty and readable while full, so the
//   two sides never touch the same bank at once.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset (discards any partial block)
//     bus - dct8_transpose_buf_if.slave (row input / column output streams)
// -----------------------------------------------------------------------------
module dct8_transpose_buf #(
   parameter int DATA_W = 32
) (
   input logic                 clk,
   input logic                 rst,
   dct8_transpose_buf_if.slave bus
);
   typedef logic [DATA_W-1:0] word_t;

   word_t      mem [2][8][8];   // [bank][row][col]
   word_t      in_row   [8];
   word_t      col_data [8];

   logic [1:0] full;
   logic       wr_bank, rd_bank;
   logic [2:0] wr_row,  rd_col;

   logic       in_ready_int, out_valid_int;
   logic       wr_fire, rd_fire;
   logic       wr_done, rd_done;
   logic [1:0] full_set, full_clr;

   // Handshake qualifiers. Both ready and valid depend only on registered
   // flags (and rst), so neither side sees a combinational path from the other.
   assign in_ready_int  = !rst && !full[wr_bank];
   assign out_valid_int = !rst && full[rd_bank];
   assign wr_fire       = bus.in_valid && in_ready_int;
   assign rd_fire       = out_valid_int && bus.out_ready;
   assign wr_done       = wr_fire && (wr_row == 3'd7);
   assign rd_done       = rd_fire && (rd_col == 3'd7);

   // A completing write and a completing read always target different banks
   // (one needs the bank empty, the other full), so set and clear never collide.
   assign full_set = wr_done ? (2'b01 << wr_bank) : 2'b00;
   assign full_clr = rd_done ? (2'b01 << rd_bank) : 2'b00;

   always_comb begin
      in_row[0] = bus.in0;
      in_row[1] = bus.in1;
      in_row[2] = bus.in2;
      in_row[3] = bus.in3;
      in_row[4] = bus.in4;
      in_row[5] = bus.in5;
      in_row[6] = bus.in6;
      in_row[7] = bus.in7;
   end

   // NOTE: storage is deliberately not reset; the full flags alone decide what
   // is readable, so stale contents are never observed and the array can map
   // onto plain RAM without a reset network.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int k = 0; k < 8; k++) begin
            mem[wr_bank][wr_row][k] <= in_row[k];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         wr_row  <= 3'd0;
         rd_bank <= 1'b0;
         rd_col  <= 3'd0;
      end else begin
         full <= (full & ~full_clr) | full_set;
         if (wr_fire) begin
            wr_row <= wr_row + 3'd1;          // wraps 7 -> 0
            if (wr_done) wr_bank <= !wr_bank;
         end
         if (rd_fire) begin
            rd_col <= rd_col + 3'd1;          // wraps 7 -> 0
            if (rd_done) rd_bank <= !rd_bank;
         end
      end
   end

   // Column read-out: word K of the column comes from row K of the bank.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         col_data[k] = out_valid_int ? mem[rd_bank][k][rd_col] : '0;
      end
   end

   // NOTE: every output gets a value on every path (zeroed when idle), so no
   // latch is inferred here.
   always_comb begin
      bus.in_ready  = in_ready_int;
      bus.out_valid = out_valid_int;
      bus.out_col   = out_valid_int ? rd_col : 3'd0;
      bus.out_last  = out_valid_int && (rd_col == 3'd7);
      bus.out0      = col_data[0];
      bus.out1      = col_data[1];
      bus.out2      = col_data[2];
      bus.out3      = col_data[3];
      bus.out4      = col_data[4];
      bus.out5      = col_data[5];
      bus.out6      = col_data[6];
      bus.out7      = col_data[7];
   end
endmodule

// File: tb/tb_dct8_transpose_buf.sv
// -----------------------------------------------------------------------------
// tb_dct8_transpose_buf
//   Bench for dct8_transpose_buf. A reference model holds completed blocks as
//   plain row-major word lists; the expected column at index c of the oldest
//   block is word K*8+c for output K. Outputs are compared on every falling
//   edge; stimulus is driven shortly after the rising edge.
// -----------------------------------------------------------------------------
module tb_dct8_transpose_buf;
   localparam int DATA_W = 32;
   localparam int BUDGET = 3000;

   typedef logic [DATA_W-1:0] word_t;
   typedef word_t row_t [8];

   logic clk = 1'b0;
   logic rst;

   dct8_transpose_buf_if #(.DATA_W(DATA_W)) bus ();

   dct8_transpose_buf #(.DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   word_t outv [8];
   always_comb begin
      outv[0] = bus.out0; outv[1] = bus.out1; outv[2] = bus.out2; outv[3] = bus.out3;
      outv[4] = bus.out4; outv[5] = bus.out5; outv[6] = bus.out6; outv[7] = bus.out7;
   end

   // ---------------- reference model state ----------------
   word_t blk_q [$];     // completed blocks, 64 words each, row-major
   row_t  part  [8];     // rows of the block currently being written
   int    part_n   = 0;
   int    col_m    = 0;
   int    cyc      = 0;
   int    done_cyc = 0;
   int    acc_cnt  = 0;
   int    out_cnt  = 0;
   logic  fire_in  = 1'b0;

   logic  prev_stall = 1'b0;
   word_t prev_out [8];
   logic [2:0] prev_col;

   // ---------------- compare + model update ----------------
   always @(negedge clk) begin : cmp
      int pend;
      row_t r;
      cyc++;
      pend = blk_q.size() / 64;
      if (rst) begin
         check("rst_in_ready", bus.in_ready, 0);
         check("rst_out_valid", bus.out_valid, 0);
         for (int k = 0; k < 8; k++) check($sformatf("rst_out%0d", k), outv[k], 0);
         check("rst_out_col", bus.out_col, 0);
         check("rst_out_last", bus.out_last, 0);
         blk_q.delete();
         part_n     = 0;
         col_m      = 0;
         prev_stall = 1'b0;
      end else begin
         check("in_ready", bus.in_ready, pend < 2);
         check("out_valid", bus.out_valid, pend > 0);
         if (pend > 0) begin
            for (int k = 0; k < 8; k++)
               check($sformatf("out%0d col%0d", k, col_m), outv[k], blk_q[k*8 + col_m]);
            check("out_col", bus.out_col, col_m);
            check("out_last", bus.out_last, col_m == 7);
         end else begin
            for (int k = 0; k < 8; k++) check($sformatf("idle_out%0d", k), outv[k], 0);
            check("idle_out_col", bus.out_col, 0);
            check("idle_out_last", bus.out_last, 0);
         end
         if (prev_stall) begin
            for (int k = 0; k < 8; k++) check($sformatf("stall_out%0d", k), outv[k], prev_out[k]);
            check("stall_out_col", bus.out_col, prev_col);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         for (int k = 0; k < 8; k++) prev_out[k] = outv[k];
         prev_col = bus.out_col;

         // Handshakes at this cycle take effect at the next rising edge.
         if (bus.in_valid && bus.in_ready) begin
            acc_cnt++;
            r[0] = bus.in0; r[1] = bus.in1; r[2] = bus.in2; r[3] = bus.in3;
            r[4] = bus.in4; r[5] = bus.in5; r[6] = bus.in6; r[7] = bus.in7;
            part[part_n] = r;
            part_n++;
            if (part_n == 8) begin
               for (int i = 0; i < 8; i++)
                  for (int c = 0; c < 8; c++) blk_q.push_back(part[i][c]);
               part_n   = 0;
               done_cyc = cyc;
            end
         end
         if (bus.out_valid && bus.out_ready && pend > 0) begin
            out_cnt++;
            if (col_m == 7) begin
               for (int i = 0; i < 64; i++) void'(blk_q.pop_front());
               col_m = 0;
            end else begin
               col_m++;
            end
         end
      end
      fire_in = bus.in_valid && bus.in_ready;
   end

   // ---------------- row source ----------------
   row_t row_q [$];
   logic rnd_rdy = 1'b0;

   always @(posedge clk) begin
      #1;
      if (fire_in && row_q.size() > 0) void'(row_q.pop_front());
      if (row_q.size() > 0) begin
         bus.in_valid = 1'b1;
         bus.in0 = row_q[0][0]; bus.in1 = row_q[0][1]; bus.in2 = row_q[0][2]; bus.in3 = row_q[0][3];
         bus.in4 = row_q[0][4]; bus.in5 = row_q[0][5]; bus.in6 = row_q[0][6]; bus.in7 = row_q[0][7];
      end else begin
         bus.in_valid = 1'b0;
      end
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
   end

   // kind 0: in(r,c) = r*8+c+off; kind 1: random signed with extremes.
   task automatic add_rows(input int kind, input int off, input int nrows);
      row_t r;
      for (int i = 0; i < nrows; i++) begin
         for (int c = 0; c < 8; c++) begin
            if (kind == 0) begin
               r[c] = word_t'(i*8 + c + off);
            end else begin
               r[c] = $urandom;
               if ($urandom_range(0, 7) == 0)
                  r[c] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7fff_ffff;
            end
         end
         if (kind == 1 && i == 0) r[0] = 32'h8000_0000;
         if (kind == 1 && i == 7) r[7] = 32'h7fff_ffff;
         row_q.push_back(r);
      end
   endtask

   task automatic ctl_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (bus.out_valid) break;
      end
      check(name, bus.out_valid, 1);
   endtask

   task automatic wait_acc(input string name, input int target);
      for (int i = 0; i < BUDGET; i++) begin
         if (acc_cnt >= target) break;
         @(negedge clk); #1;
      end
      check(name, acc_cnt >= target, 1);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < BUDGET; i++) begin
         @(negedge clk); #1;
         if (row_q.size() == 0 && blk_q.size() == 0 && part_n == 0 && !bus.in_valid) break;
      end
      check(name, (row_q.size() == 0 && blk_q.size() == 0 && part_n == 0), 1);
   endtask

   initial begin
      int base;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      {bus.in0, bus.in1, bus.in2, bus.in3, bus.in4, bus.in5, bus.in6, bus.in7} = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Single block, pinned literal values.
      bus.out_ready = 1'b1;
      add_rows(0, 0, 8);
      wait_valid("t1_first_valid");
      check("t1_latency", cyc - done_cyc, 1);
      for (int c = 0; c < 8; c++) begin
         check($sformatf("t1_out5_beat%0d", c), bus.out5, 40 + c);
         check($sformatf("t1_out0_beat%0d", c), bus.out0, c);
         check($sformatf("t1_col_beat%0d", c), bus.out_col, c);
         check($sformatf("t1_last_beat%0d", c), bus.out_last, c == 7);
         @(negedge clk); #1;
      end
      wait_idle("t1_idle");

      // Two back-to-back blocks: no gap, second block offset by 100. Beat 8 is
      // also the cycle after a write completion and read completion coincide.
      ctl_edge();
      add_rows(0, 0, 8);
      add_rows(0, 100, 8);
      wait_valid("t2_first_valid");
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t2_gapless_%0d", i), bus.out_valid, 1);
         if (i < 8) check($sformatf("t2_in_ready_%0d", i), bus.in_ready, 1);
         if (i == 8) begin
            check("t2_blk2_col", bus.out_col, 0);
            check("t2_blk2_out0", bus.out0, 100);
            check("t2_blk2_out7", bus.out7, 156);
         end
         @(negedge clk); #1;
      end
      wait_idle("t2_idle");

      // Stall output: both banks fill, then one bank drains and input resumes.
      ctl_edge();
      bus.out_ready = 1'b0;
      base = acc_cnt;
      add_rows(0, 200, 8);
      add_rows(0, 300, 8);
      add_rows(0, 400, 8);
      wait_acc("t3_fill", base + 16);
      repeat (4) @(negedge clk);
      #1;
      check("t3_accepts_stalled", acc_cnt - base, 16);
      check("t3_in_ready_low", bus.in_ready, 0);
      ctl_edge();
      bus.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #2 bus.out_ready = 1'b0;
      @(negedge clk); #1;
      check("t3_in_ready_back", bus.in_ready, 1);
      check("t3_blk3_row0", acc_cnt - base, 17);
      ctl_edge();
      bus.out_ready = 1'b1;
      wait_idle("t3_idle");

      // Random backpressure over random signed blocks.
      ctl_edge();
      rnd_rdy = 1'b1;
      for (int b = 0; b < 10; b++) add_rows(1, 0, 8);
      wait_idle("t4_idle");
      ctl_edge();
      rnd_rdy = 1'b0;
      bus.out_ready = 1'b0;

      // Reset mid-stream: one block partly drained, the next partly written.
      base = acc_cnt;
      add_rows(0, 600, 8);
      add_rows(0, 700, 4);
      wait_acc("t5_fill", base + 12);
      ctl_edge();
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 bus.out_ready = 1'b0;
      check("t5_drained3", out_cnt > 0, 1);
      rst = 1'b1;
      row_q.delete();
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk); #1;
      check("t5_post_rst_valid", bus.out_valid, 0);
      check("t5_post_rst_ready", bus.in_ready, 1);
      ctl_edge();
      bus.out_ready = 1'b1;
      add_rows(0, 500, 8);
      wait_valid("t5_b_valid");
      check("t5_b_out0", bus.out0, 500);
      check("t5_b_out7", bus.out7, 556);
      wait_idle("t5_idle");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
